fsm_trace_monitor: RTL and testbench
====================================

# fsm_trace_monitor

Downstream checker for the octal-digit sequence FSM (states 0, 3, 2, 4, 5 driven by input `a`). Samples the FSM's 3-bit digit output together with the `a` it was fed, predicts each next digit from the legal transition graph, and reports mismatches and illegal codes. Counters summarise activity, and a small event FIFO records each mismatch for the bench or a debug host. One instance monitors any of the FSM implementations (case, gate-level or ROM-based).

## Interface
- `FIFO_DEPTH`, 4: mismatch event FIFO entries; power of two, 2..16.
- `CHK_W`, 16: width of the check counter.
- `MIS_W`, 8: width of the mismatch counter.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous clear of counters, flags and FIFO; returns the FSM to IDLE.
- `in_valid` in 1: `digit` and `a` are sampled this edge.
- `a` in 1: input bit that was applied to the monitored FSM on this same edge.
- `digit` in 3: monitored FSM output, binary 0..7.
- `err` out 1: sticky; at least one mismatch since reset or clear.
- `illegal` out 1: sticky; a digit of 1, 6 or 7 was sampled.
- `check_cnt` out CHK_W: number of compared samples; saturating.
- `mis_cnt` out MIS_W: number of mismatches; saturating.
- `evt_valid` out 1: FIFO head is valid.
- `evt_data` out 6: {expected[5:3], got[2:0]} of the oldest mismatch.
- `evt_ready` in 1: pops the head when `evt_valid` is high.
- `evt_ovf` out 1: sticky; a push was dropped because the FIFO was full.

## Operation
- Transition function nxt(d, a):
  - 0→3
  - 3→(a ? 5 : 2)
  - 2→4
  - 4→(a ? 3 : 0)
  - 5→2
  - 1, 6 and 7 are illegal and have no successor.
- Sampling: on each edge with `in_valid`=1, the monitor registers `prev_d`=`digit` and `prev_a`=`a`. Edges with `in_valid`=0 change nothing.
- State machine states:
  - IDLE:
    - On a legal sample: store it, go to TRACK. No compare, no count.
    - On an illegal sample: set `illegal`, stay in IDLE.
  - TRACK:
    - Every valid sample: compare `digit` against nxt(`prev_d`, `prev_a`) and increment `check_cnt`.
    - On equal: store the sample, stay in TRACK.
    - On differ (an illegal digit always differs): increment `mis_cnt`, set `err`, push {expected, digit}, store the sample, go to RESYNC.
  - RESYNC:
    - Next valid sample: not compared, not counted; this absorbs the faulty predecessor.
    - On a legal sample: go to TRACK. On an illegal sample: set `illegal`, stay in RESYNC.
- Illegal digits set `illegal` in any state.
- Counters saturate at all-ones and never wrap.
- FIFO:
  - Push on mismatch; pop on `evt_valid` && `evt_ready`.
  - Pop and push in the same cycle on a full FIFO: both succeed, `evt_ovf` is not set.
  - Push while full with no pop: the new entry is dropped and `evt_ovf` is set.
  - Pop while empty is ignored.
- `clear` has priority over sampling and FIFO operations in the same cycle.

## Timing
- All outputs are registered.
- Reset values: `err`=0, `illegal`=0, `check_cnt`=0, `mis_cnt`=0, `evt_valid`=0, `evt_data`=0, `evt_ovf`=0. FSM is in IDLE, FIFO empty.
- A mismatch sampled on edge k appears in `err`, `mis_cnt` and `evt_valid` after edge k (visible in cycle k+1).
- `evt_data` shows the head combinationally from FIFO storage; it is valid whenever `evt_valid`=1.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock.

## Configuration
- `FSM_TRACE_MON_FIFO_EN`:
  - Defined: event FIFO is built as specified.
  - Undefined: no FIFO storage. `evt_valid`, `evt_data` and `evt_ovf` are tied to 0 and `evt_ready` is ignored. Counters and flags are unchanged.

## Structure
- `fsm_trace_mon_pkg` holds:
  - Digit constants D0, D2, D3, D4, D5.
  - Monitor state enum: IDLE, TRACK, RESYNC.
  - Function `nxt_digit(d, a)` and function `is_legal(d)`.
  - Event struct {expected, got}.
- One sub-module, `fsm_trace_mon_fifo`: synchronous FIFO with `clk`/`reset`, `clear`, push/pop, `full`, `empty` and `ovf`.

## Test plan
1. **Legal trace.** Reset, then `in_valid`=1 with digit sequence 0,3,2,4,0,3,5,2,4,3 and `a`=0,0,0,0,0,1,0,0,1,0.
   → `check_cnt`=9, `mis_cnt`=0, `err`=0, `evt_valid`=0.
2. **Single mismatch.** Digits 0,3,4,2 with `a`=0.
   → On the third sample, push {2,4}, `mis_cnt`=1, `err`=1. The fourth sample is not compared (RESYNC), so `check_cnt`=2.
3. **Illegal code.** Digits 0,3,7,3,5 with `a`=0,1,0,0,0.
   → `illegal`=1, `mis_cnt`=1, event {5,7}.
   → The fourth sample (3) is legal, so the monitor returns to TRACK.
   → The fifth sample (5) is compared against nxt(3,0)=2 and mismatches: `mis_cnt`=2, second event {2,5}.
4. **FIFO overflow.** Force 5 mismatches with `evt_ready`=0.
   → Four entries held, `evt_ovf`=1.
   → Then pop and push in the same cycle while full: occupancy stays 4.
5. **Clear and reset mid-run.**
   - `clear` asserted in the same cycle as a mismatching sample: all counters and flags read 0 next cycle, FSM is in IDLE.
   - Async `reset` low mid-clock: outputs go to 0 before the next edge.
6. **Saturation.** Run `CHK_W`=4 and `MIS_W`=2 with 20 samples including alternating errors.
   → `check_cnt` holds at 15 and `mis_cnt` holds at 3.

Source files
------------

// File: rtl/fsm_trace_mon_pkg.sv
// fsm_trace_mon_pkg: digit codes, monitor states, event record and transition helpers
package fsm_trace_mon_pkg;

    localparam logic [2:0] D0 = 3'd0;
    localparam logic [2:0] D2 = 3'd2;
    localparam logic [2:0] D3 = 3'd3;
    localparam logic [2:0] D4 = 3'd4;
    localparam logic [2:0] D5 = 3'd5;

    typedef enum logic [1:0] {IDLE, TRACK, RESYNC} mon_state_e;

    typedef struct packed {
        logic [2:0] expected;
        logic [2:0] got;
    } evt_t;

    function automatic logic is_legal(input logic [2:0] d);
        return d == D0 || d == D2 || d == D3 || d == D4 || d == D5;
    endfunction

    // Illegal codes never reach here in TRACK, so their D0 fallback is arbitrary
    function automatic logic [2:0] nxt_digit(input logic [2:0] d, input logic a);
        return d == D0 ? D3 :
               d == D3 ? (a ? D5 : D2) :
               d == D2 ? D4 :
               d == D4 ? (a ? D3 : D0) :
               d == D5 ? D2 : D0;
    endfunction

endpackage

// File: rtl/fsm_trace_mon_fifo.sv
// fsm_trace_mon_fifo: event FIFO; a push while full without a pop is dropped and sets sticky ovf
module fsm_trace_mon_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic         ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d, do_push, do_pop;

    assign empty   = cnt_q == '0;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;
    assign rdata   = empty ? '0 : mem_q[rd_q];
    assign ovf     = ovf_q;

    always_comb begin
        wr_d  = clear ? '0 : wr_q + AW'(do_push);
        rd_d  = clear ? '0 : rd_q + AW'(do_pop);
        cnt_d = clear ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        ovf_d = !clear && (ovf_q || (push && full && !do_pop));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/fsm_trace_monitor.sv
// fsm_trace_monitor: predicts and checks the octal-digit FSM trace; counters, sticky flags
// and, with FSM_TRACE_MON_FIFO_EN defined, a mismatch event FIFO
module fsm_trace_monitor
    import fsm_trace_mon_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CHK_W      = 16,
    parameter int MIS_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             a,
    input  logic [2:0]       digit,
    output logic             err,
    output logic             illegal,
    output logic [CHK_W-1:0] check_cnt,
    output logic [MIS_W-1:0] mis_cnt,
    output logic             evt_valid,
    output logic [5:0]       evt_data,
    input  logic             evt_ready,
    output logic             evt_ovf
);

    mon_state_e       state_q, state_d;
    logic [2:0]       prev_d_q, prev_d_d, exp_dig;
    logic             prev_a_q, prev_a_d;
    logic             err_q, err_d, illegal_q, illegal_d;
    logic [CHK_W-1:0] check_cnt_q, check_cnt_d;
    logic [MIS_W-1:0] mis_cnt_q, mis_cnt_d;
    logic             legal, cmp, mis;

    assign legal   = is_legal(digit);
    assign exp_dig = nxt_digit(prev_d_q, prev_a_q);
    assign cmp     = in_valid && state_q == TRACK;
    assign mis     = cmp && digit != exp_dig;

    always_comb begin
        state_d     = state_q;
        prev_d_d    = prev_d_q;
        prev_a_d    = prev_a_q;
        err_d       = err_q;
        illegal_d   = illegal_q;
        check_cnt_d = check_cnt_q;
        mis_cnt_d   = mis_cnt_q;
        if (clear) begin
            state_d     = IDLE;
            prev_d_d    = '0;
            prev_a_d    = 1'b0;
            err_d       = 1'b0;
            illegal_d   = 1'b0;
            check_cnt_d = '0;
            mis_cnt_d   = '0;
        end else if (in_valid) begin
            state_d     = state_q == TRACK ? (mis ? RESYNC : TRACK) : (legal ? TRACK : state_q);
            prev_d_d    = digit;
            prev_a_d    = a;
            err_d       = err_q || mis;
            illegal_d   = illegal_q || !legal;
            check_cnt_d = (cmp && !(&check_cnt_q)) ? check_cnt_q + CHK_W'(1) : check_cnt_q;
            mis_cnt_d   = (mis && !(&mis_cnt_q)) ? mis_cnt_q + MIS_W'(1) : mis_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            prev_d_q    <= '0;
            prev_a_q    <= 1'b0;
            err_q       <= 1'b0;
            illegal_q   <= 1'b0;
            check_cnt_q <= '0;
            mis_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_d_q    <= prev_d_d;
            prev_a_q    <= prev_a_d;
            err_q       <= err_d;
            illegal_q   <= illegal_d;
            check_cnt_q <= check_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
        end
    end

    assign err       = err_q;
    assign illegal   = illegal_q;
    assign check_cnt = check_cnt_q;
    assign mis_cnt   = mis_cnt_q;

`ifdef FSM_TRACE_MON_FIFO_EN
    evt_t ev;
    logic fifo_empty, unused_full;

    assign ev = '{expected: exp_dig, got: digit};

    fsm_trace_mon_fifo #(.DEPTH(FIFO_DEPTH), .W(6)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (mis),
        .pop   (evt_ready),
        .wdata (ev),
        .rdata (evt_data),
        .full  (unused_full),
        .empty (fifo_empty),
        .ovf   (evt_ovf)
    );

    assign evt_valid = !fifo_empty;
`else
    logic unused_ready;

    assign unused_ready = evt_ready;
    assign evt_valid    = 1'b0;
    assign evt_data     = '0;
    assign evt_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_trace_monitor.sv
// tb_fsm_trace_monitor: directed traces with an event scoreboard popped by a separate monitor
module tb_fsm_trace_monitor;

`ifdef FSM_TRACE_MON_FIFO_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0, clear = 1'b0, in_valid = 1'b0, a = 1'b0, evt_ready = 1'b0;
    logic [2:0]  digit = 3'd0;
    logic        err, illegal, evt_valid, evt_ovf;
    logic [15:0] check_cnt;
    logic [7:0]  mis_cnt;
    logic [5:0]  evt_data;

    logic        s_clear = 1'b0, s_valid = 1'b0, s_a = 1'b0;
    logic [2:0]  s_digit = 3'd0;
    logic        s_err, s_illegal, s_evt_valid, s_evt_ovf;
    logic [3:0]  s_check;
    logic [1:0]  s_mis;
    logic [5:0]  s_evt_data;

    int         checks = 0, fails = 0, pops = 0, p0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    fsm_trace_monitor #(.FIFO_DEPTH(4), .CHK_W(16), .MIS_W(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .a(a), .digit(digit),
        .err(err), .illegal(illegal), .check_cnt(check_cnt), .mis_cnt(mis_cnt),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready), .evt_ovf(evt_ovf)
    );

    fsm_trace_monitor #(.FIFO_DEPTH(2), .CHK_W(4), .MIS_W(2)) dut_s (
        .clk(clk), .reset(reset), .clear(s_clear), .in_valid(s_valid), .a(s_a), .digit(s_digit),
        .err(s_err), .illegal(s_illegal), .check_cnt(s_check), .mis_cnt(s_mis),
        .evt_valid(s_evt_valid), .evt_data(s_evt_data), .evt_ready(1'b0), .evt_ovf(s_evt_ovf)
    );

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    task automatic exp_push(input logic [5:0] e);
        if (FE) exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset && evt_valid && evt_ready) begin
            pops++;
            if (exp_q.size() == 0) chk("evt_unexpected", {26'd0, evt_data}, 32'hffff_ffff);
            else chk("evt_data_sb", {26'd0, evt_data}, {26'd0, exp_q.pop_front()});
        end
    end

    task automatic drv(input logic v, input logic [2:0] d, input logic av, input logic r, input logic c);
        @(posedge clk);
        #2;
        in_valid = v; digit = d; a = av; evt_ready = r; clear = c;
    endtask

    task automatic idle();
        drv(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic [63:0] ds, input logic [15:0] as, input logic [15:0] rs);
        for (int i = 0; i < n; i++) drv(1'b1, ds[3*(n-1-i) +: 3], as[n-1-i], rs[n-1-i], 1'b0);
        idle();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        idle();
    endtask

    task automatic clr();
        drv(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        chk("rst_err", err, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_check_cnt", check_cnt, 0);
        chk("rst_mis_cnt", mis_cnt, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_data", evt_data, 0);
        chk("rst_evt_ovf", evt_ovf, 0);
        reset = 1'b1;

        run(10, 64'o0324035243, 16'b0000010010, 16'd0);
        chk("t1_check_cnt", check_cnt, 9);
        chk("t1_mis_cnt", mis_cnt, 0);
        chk("t1_err", err, 0);
        chk("t1_illegal", illegal, 0);
        chk("t1_evt_valid", evt_valid, 0);
        clr();
        chk("clr_check_cnt", check_cnt, 0);

        exp_push(6'o24);
        run(4, 64'o0342, 16'd0, 16'd0);
        chk("t2_check_cnt", check_cnt, 2);
        chk("t2_mis_cnt", mis_cnt, 1);
        chk("t2_err", err, 1);
        chk("t2_evt_valid", evt_valid, FE);
        chk("t2_evt_data", evt_data, FE ? 6'o24 : 6'o00);
        drain(2);
        chk("t2_evt_empty", evt_valid, 0);
        clr();

        exp_push(6'o57);
        exp_push(6'o25);
        run(5, 64'o03735, 16'b01000, 16'd0);
        chk("t3_illegal", illegal, 1);
        chk("t3_mis_cnt", mis_cnt, 2);
        chk("t3_check_cnt", check_cnt, 3);
        chk("t3_err", err, 1);
        drain(3);
        clr();
        chk("t3_clr_illegal", illegal, 0);

        p0 = pops;
        exp_push(6'o32);
        exp_push(6'o03);
        exp_push(6'o24);
        exp_push(6'o40);
        exp_push(6'o35);
        run(10, 64'o0243542005, 16'd0, 16'b0000000001);
        chk("t4_mis_cnt_a", mis_cnt, 5);
        chk("t4_ovf_popush", evt_ovf, 0);
        chk("t4_evt_valid", evt_valid, FE);
        run(2, 64'o23, 16'd0, 16'd0);
        chk("t4_mis_cnt_b", mis_cnt, 6);
        chk("t4_check_cnt", check_cnt, 6);
        chk("t4_ovf", evt_ovf, FE);
        drain(6);
        chk("t4_pops", pops - p0, FE ? 5 : 0);
        chk("t4_ovf_sticky", evt_ovf, FE);
        clr();
        chk("t4_clr_ovf", evt_ovf, 0);

        run(2, 64'o03, 16'd0, 16'd0);
        chk("t5_pre_check_cnt", check_cnt, 1);
        drv(1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
        idle();
        chk("t5_clr_check_cnt", check_cnt, 0);
        chk("t5_clr_mis_cnt", mis_cnt, 0);
        chk("t5_clr_err", err, 0);
        chk("t5_clr_evt_valid", evt_valid, 0);
        run(2, 64'o40, 16'd0, 16'd0);
        chk("t5_idle_check_cnt", check_cnt, 1);
        chk("t5_idle_mis_cnt", mis_cnt, 0);
        run(1, 64'o4, 16'd0, 16'd0);
        chk("t5_pre_rst_err", err, 1);
        chk("t5_pre_rst_evt_valid", evt_valid, FE);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("t5_arst_err", err, 0);
        chk("t5_arst_check_cnt", check_cnt, 0);
        chk("t5_arst_mis_cnt", mis_cnt, 0);
        chk("t5_arst_evt_valid", evt_valid, 0);
        @(negedge clk);
        reset = 1'b1;

        begin
            logic [63:0] ds;
            ds = 64'o03403240340324034034;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #2;
                s_valid = 1'b1;
                s_digit = ds[3*(19-i) +: 3];
                s_a = 1'b0;
            end
            @(posedge clk);
            #2;
            s_valid = 1'b0;
            @(negedge clk);
        end
        chk("t6_check_sat", s_check, 15);
        chk("t6_mis_sat", s_mis, 3);
        chk("t6_err", s_err, 1);

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
